conv_encoder_framed: RTL and testbench
======================================

// Module: conv_encoder_framed
// PURPOSE
//  Rate-1/2 convolutional encoder: the transmit end feeding the Viterbi decoder through the channel.
//  Accepts serial data bits in frames of FRAME_LEN and emits one 2-bit code symbol per bit.
//  After each frame, appends K-1 zero tail bits so the trellis ends in state 0 at every frame boundary.
//  Marks the first and last symbol of each frame for the decoder and the bench.
// PARAMETERS
//  K          7        constraint length (3..9); shift register holds K-1 previous bits
//  G0         7'o171   generator polynomial for d_out[1], K bits wide, MSB taps the current bit
//  G1         7'o133   generator polynomial for d_out[0], K bits wide, MSB taps the current bit
//  FRAME_LEN  64       data bits per frame (>=1)
// PORTS
//  clk        in   1   clock, all logic on posedge
//  rst        in   1   synchronous reset, active-high
//  enable_i   in   1   d_in valid this cycle; a bit is accepted only when enable_i && ready_o
//  d_in       in   1   serial data bit
//  ready_o    out  1   encoder can accept a data bit (low during tail flush)
//  valid_o    out  1   d_out holds a code symbol this cycle
//  d_out      out  2   code symbol {parity G0, parity G1}
//  sof_o      out  1   with valid_o: first symbol of a frame
//  eof_o      out  1   with valid_o: last tail symbol of a frame
//  frame_ct   out  16  completed frames since reset, wraps 16'hFFFF->0
// BEHAVIOUR
//  Reset: state=IDLE, shift reg sr=0, bit_ct=0, tail_ct=0, valid_o=0, d_out=2'b00, sof_o=0, eof_o=0,
//   frame_ct=0; ready_o=1 from the first cycle after reset.
//  Encoding: vector v={b, sr[0], sr[1], ..., sr[K-2]} (b = current input, sr[0] = most recent previous bit).
//   d_out[1]=^(v & G0), d_out[0]=^(v & G1). On encode: sr <= {sr[K-3:0], b}.
//  Latency: all outputs registered; symbol for a bit accepted in cycle n is valid in cycle n+1.
//  FSM IDLE / DATA / TAIL:
//   IDLE: ready_o=1. On accept: encode d_in, sof_o=1 on that symbol, bit_ct=1.
//    Next state DATA; if FRAME_LEN==1, next state TAIL.
//   DATA: ready_o=1. Each accept encodes d_in, bit_ct++.
//    The accept that makes bit_ct==FRAME_LEN moves to TAIL with tail_ct=0.
//    No accept in a cycle -> valid_o=0 next cycle, sr unchanged; gaps of any length are legal.
//   TAIL: ready_o=0, enable_i/d_in ignored. Each cycle encode b=0, valid_o=1, tail_ct++.
//    On the (K-1)th tail symbol: eof_o=1, frame_ct++, state to IDLE, bit_ct=0. sr is all-zero by construction.
//  Symbols per frame: exactly FRAME_LEN+K-1, with sof_o once and eof_o once. sof_o and eof_o are never both set.
//  Back-to-back: a bit may be accepted in the cycle IDLE is entered; the next frame's sof symbol
//   directly follows the eof symbol, with no idle symbol between them.
//  ready_o is combinational from state only (not from enable_i).
//  rst asserted mid-frame: frame abandoned with no eof_o; all state returns to reset values next cycle.
//   frame_ct is cleared.
//  valid_o=0 -> d_out, sof_o and eof_o are driven 0.
// TESTING
//  (K=7, G0=171, G1=133 unless stated)
//  Impulse, FRAME_LEN=1, d_in=1 -> 7 symbols 11,10,11,11,00,01,11; sof on #1, eof on #7, frame_ct=1.
//  All-zero frame, FRAME_LEN=64 -> 70 symbols all 2'b00; ready_o low for exactly 6 cycles; eof on #70.
//  enable_i held high for 3 frames of FRAME_LEN=8 -> per frame 8 accepts then 6 ready_o-low cycles;
//   frame_ct ends at 3; sr=0 at each sof.
//  Random gaps in enable_i during DATA -> symbol stream identical to the gap-free run; valid_o low only in gaps.
//  rst pulse after 20 bits of a frame -> no eof_o; next frame from d_in=1 reproduces the impulse prefix 11,10,...
//  Loopback into the Viterbi decoder with zero errors -> decoded bits equal input; frame_ct wrap checked with forced value.

Source files
------------

// File: rtl/conv_encoder_framed_if.sv
// Serial-bit in / code-symbol out bundle for the framed convolutional encoder.
// The slave side is the encoder; the master side is whatever feeds and consumes it.
interface conv_encoder_framed_if;
  logic        enable_i;
  logic        d_in;
  logic        ready_o;
  logic        valid_o;
  logic [1:0]  d_out;
  logic        sof_o;
  logic        eof_o;
  logic [15:0] frame_ct;

  modport master (
    output enable_i, d_in,
    input  ready_o, valid_o, d_out, sof_o, eof_o, frame_ct
  );

  modport slave (
    input  enable_i, d_in,
    output ready_o, valid_o, d_out, sof_o, eof_o, frame_ct
  );
endinterface

// File: rtl/conv_encoder_framed.sv
// Rate-1/2 convolutional encoder with fixed-length frames and a K-1 zero tail per frame,
// so each frame's trellis terminates in state 0; symbols are tagged with sof/eof markers.
module conv_encoder_framed #(
  parameter int unsigned    K         = 7,
  parameter logic [K-1:0]   G0        = 7'o171,
  parameter logic [K-1:0]   G1        = 7'o133,
  parameter int unsigned    FRAME_LEN = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  conv_encoder_framed_if.slave bus
);

  localparam int unsigned BitW  = $clog2(FRAME_LEN + 1);
  localparam int unsigned TailW = $clog2(K);

  typedef enum logic [1:0] {StIdle, StData, StTail} state_e;

  state_e           state_q;
  logic [K-2:0]     sr_q;
  logic [BitW-1:0]  bit_ct_q;
  logic [TailW-1:0] tail_ct_q;
  logic             valid_q;
  logic [1:0]       sym_q;
  logic             sof_q;
  logic             eof_q;
  logic [15:0]      frame_ct_q;

  logic             in_tail;
  logic             accept;
  logic             enc_bit;
  logic [K-1:0]     v;
  logic [1:0]       sym;
  logic [BitW-1:0]  bit_ct_nxt;
  logic             last_bit;
  logic             last_tail;

  always_comb begin
    in_tail = (state_q == StTail);
    accept  = bus.enable_i && !in_tail;
    enc_bit = in_tail ? 1'b0 : bus.d_in;
    // Current bit in the MSB, then history from most recent (sr[0]) to oldest.
    v       = '0;
    v[K-1]  = enc_bit;
    for (int unsigned i = 0; i < K - 1; i++) begin
      v[K-2-i] = sr_q[i];
    end
    sym        = {^(v & G0), ^(v & G1)};
    bit_ct_nxt = (state_q == StIdle) ? BitW'(1) : bit_ct_q + BitW'(1);
    last_bit   = (bit_ct_nxt == BitW'(FRAME_LEN));
    last_tail  = (tail_ct_q == TailW'(K - 2));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      sr_q       <= '0;
      bit_ct_q   <= '0;
      tail_ct_q  <= '0;
      valid_q    <= 1'b0;
      sym_q      <= 2'b00;
      sof_q      <= 1'b0;
      eof_q      <= 1'b0;
      frame_ct_q <= '0;
    end else begin
      valid_q <= 1'b0;
      sym_q   <= 2'b00;
      sof_q   <= 1'b0;
      eof_q   <= 1'b0;
      unique case (state_q)
        StIdle, StData: begin
          if (accept) begin
            valid_q  <= 1'b1;
            sym_q    <= sym;
            sof_q    <= (state_q == StIdle);
            sr_q     <= {sr_q[K-3:0], enc_bit};
            bit_ct_q <= bit_ct_nxt;
            if (last_bit) begin
              state_q   <= StTail;
              tail_ct_q <= '0;
            end else begin
              state_q <= StData;
            end
          end
        end
        StTail: begin
          valid_q   <= 1'b1;
          sym_q     <= sym;
          sr_q      <= {sr_q[K-3:0], enc_bit};
          tail_ct_q <= tail_ct_q + TailW'(1);
          if (last_tail) begin
            eof_q      <= 1'b1;
            frame_ct_q <= frame_ct_q + 16'd1;
            state_q    <= StIdle;
            bit_ct_q   <= '0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.ready_o  = (state_q != StTail);
  assign bus.valid_o  = valid_q;
  assign bus.d_out    = sym_q;
  assign bus.sof_o    = sof_q;
  assign bus.eof_o    = eof_q;
  assign bus.frame_ct = frame_ct_q;

endmodule

// File: tb/tb_conv_encoder_framed.sv
// Directed bench for conv_encoder_framed: an 8-bit-frame instance for framing, gaps and reset,
// plus a 1-bit-frame instance for the impulse response.
module tb_conv_encoder_framed;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  conv_encoder_framed_if bus8();
  conv_encoder_framed_if bus1();

  conv_encoder_framed #(.K(7), .G0(7'o171), .G1(7'o133), .FRAME_LEN(8)) u_dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8.slave)
  );

  conv_encoder_framed #(.K(7), .G0(7'o171), .G1(7'o133), .FRAME_LEN(1)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1.slave)
  );

  localparam logic [6:0] MG0 = 7'o171;
  localparam logic [6:0] MG1 = 7'o133;

  int         n_cmp = 0;
  int         n_err = 0;
  logic [5:0] msr;
  logic [1:0] seen[$];
  logic [1:0] imp[7] = '{2'b11, 2'b10, 2'b11, 2'b11, 2'b00, 2'b01, 2'b11};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference encoder: msr[0] is the most recent previous bit.
  task automatic model(input logic b, output logic [1:0] s);
    logic [6:0] v;
    v   = {b, msr[0], msr[1], msr[2], msr[3], msr[4], msr[5]};
    s   = {^(v & MG0), ^(v & MG1)};
    msr = {msr[4:0], b};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Send one 8-bit frame MSB first; gaps[7-i] inserts an idle cycle before bit i.
  task automatic run_frame8(input logic [7:0] bits, input logic [7:0] gaps, input string tag);
    logic [1:0] exp;
    for (int i = 0; i < 8; i++) begin
      if (gaps[7-i]) begin
        bus8.enable_i = 1'b0;
        bus8.d_in     = 1'b1;
        tick();
        check({tag, " gap valid"}, 32'(bus8.valid_o), 32'd0);
        check({tag, " gap d_out"}, 32'(bus8.d_out), 32'd0);
      end
      check({tag, " ready data"}, 32'(bus8.ready_o), 32'd1);
      bus8.enable_i = 1'b1;
      bus8.d_in     = bits[7-i];
      tick();
      model(bits[7-i], exp);
      seen.push_back(bus8.d_out);
      check({tag, " valid"}, 32'(bus8.valid_o), 32'd1);
      check({tag, " d_out"}, 32'(bus8.d_out), 32'(exp));
      check({tag, " sof"}, 32'(bus8.sof_o), 32'(i == 0));
      check({tag, " eof data"}, 32'(bus8.eof_o), 32'd0);
    end
    for (int j = 0; j < 6; j++) begin
      check({tag, " ready tail"}, 32'(bus8.ready_o), 32'd0);
      bus8.d_in = 1'b1;
      tick();
      model(1'b0, exp);
      check({tag, " tail valid"}, 32'(bus8.valid_o), 32'd1);
      check({tag, " tail d_out"}, 32'(bus8.d_out), 32'(exp));
      check({tag, " tail sof"}, 32'(bus8.sof_o), 32'd0);
      check({tag, " eof"}, 32'(bus8.eof_o), 32'(j == 5));
    end
  endtask

  initial begin
    logic [1:0] exp;
    logic [4:0] pre;
    bus8.enable_i = 1'b0;
    bus8.d_in     = 1'b0;
    bus1.enable_i = 1'b0;
    bus1.d_in     = 1'b0;
    msr           = '0;

    // Reset state
    tick();
    tick();
    check("rst valid", 32'(bus8.valid_o), 32'd0);
    check("rst d_out", 32'(bus8.d_out), 32'd0);
    check("rst sof", 32'(bus8.sof_o), 32'd0);
    check("rst eof", 32'(bus8.eof_o), 32'd0);
    check("rst frame_ct", 32'(bus8.frame_ct), 32'd0);
    check("rst ready", 32'(bus8.ready_o), 32'd1);
    rst = 1'b0;

    // Three back-to-back frames with enable held high
    run_frame8(8'b10110010, 8'h00, "f1");
    check("f1 frame_ct", 32'(bus8.frame_ct), 32'd1);
    run_frame8(8'b01101110, 8'h00, "f2");
    run_frame8(8'b11111111, 8'h00, "f3");
    check("f3 frame_ct", 32'(bus8.frame_ct), 32'd3);
    bus8.enable_i = 1'b0;
    tick();
    check("idle valid", 32'(bus8.valid_o), 32'd0);
    check("idle ready", 32'(bus8.ready_o), 32'd1);

    // Same data as f1 with gaps: identical symbols, valid low only in gaps
    run_frame8(8'b10110010, 8'b01011001, "gap");
    check("gap frame_ct", 32'(bus8.frame_ct), 32'd4);

    // All-zero frame
    run_frame8(8'h00, 8'h00, "zero");
    check("zero ready after", 32'(bus8.ready_o), 32'd1);
    check("zero frame_ct", 32'(bus8.frame_ct), 32'd5);

    // Abandon a frame mid-way with reset
    pre = 5'b11010;
    for (int i = 0; i < 5; i++) begin
      bus8.enable_i = 1'b1;
      bus8.d_in     = pre[4-i];
      tick();
      model(pre[4-i], exp);
      check("pre d_out", 32'(bus8.d_out), 32'(exp));
      check("pre eof", 32'(bus8.eof_o), 32'd0);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    msr = '0;
    check("mid rst valid", 32'(bus8.valid_o), 32'd0);
    check("mid rst eof", 32'(bus8.eof_o), 32'd0);
    check("mid rst frame_ct", 32'(bus8.frame_ct), 32'd0);
    check("mid rst ready", 32'(bus8.ready_o), 32'd1);
    seen.delete();
    run_frame8(8'b10000000, 8'h00, "imp8");
    check("imp8 sym0", 32'(seen[0]), 32'(2'b11));
    check("imp8 sym1", 32'(seen[1]), 32'(2'b10));
    check("imp8 sym2", 32'(seen[2]), 32'(2'b11));
    check("imp8 frame_ct", 32'(bus8.frame_ct), 32'd1);
    bus8.enable_i = 1'b0;

    // Impulse through the single-bit-frame instance
    bus1.enable_i = 1'b1;
    bus1.d_in     = 1'b1;
    tick();
    bus1.enable_i = 1'b0;
    bus1.d_in     = 1'b0;
    for (int k = 0; k < 7; k++) begin
      if (k > 0) tick();
      check("imp1 valid", 32'(bus1.valid_o), 32'd1);
      check("imp1 d_out", 32'(bus1.d_out), 32'(imp[k]));
      check("imp1 sof", 32'(bus1.sof_o), 32'(k == 0));
      check("imp1 eof", 32'(bus1.eof_o), 32'(k == 6));
    end
    tick();
    check("imp1 valid end", 32'(bus1.valid_o), 32'd0);
    check("imp1 frame_ct", 32'(bus1.frame_ct), 32'd1);
    check("imp1 ready end", 32'(bus1.ready_o), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
